// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the digits shown on a multiplexed 6-digit, 7-segment display by
//   watching its segment and digit-select lines. It publishes a complete frame
//   once every digit position has been captured.
//
//   Optional feature: define SEG_SCAN_HEX_EN to also decode the hex glyphs
//   A b C d E F. Without it, those glyphs are treated as undecodable.
//
// Parameters
//   STABLE_CYC  consecutive identical samples before a digit is captured (1..15)
//   TIMEOUT     cycles without a legal select before scan_lost asserts (2..255)
//
// Ports
//   CLK1K       1 kHz system clock; all logic runs on its rising edge
//   RST         synchronous active-high reset
//   seg[6:0]    segment lines, active-high, seg[0]=a .. seg[6]=g
//   dig[5:0]    digit selects, active-low one-hot, dig[0] = digit 0
//   digits      last complete frame, digits[4i+3:4i] = digit i
//   blank       last complete frame, bit i set = digit i was dark
//   frame_done  one-cycle pulse when digits/blank are reloaded
//   err         one-cycle pulse on an illegal capture (bad glyph or multi-select)
//   scan_lost   level, no legal select seen for TIMEOUT cycles
module seg_scan_decoder #(
  parameter int STABLE_CYC = 2,
  parameter int TIMEOUT    = 50
) (
  input  logic        CLK1K,
  input  logic        RST,
  input  logic [6:0]  seg,
  input  logic [5:0]  dig,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic        frame_done,
  output logic        err,
  output logic        scan_lost
);

  // dwell holds (number of identical consecutive samples - 1). Capture happens
  // when it equals STABLE_CYC-1. Because the counter saturates at 15, which is
  // above any legal trigger value, each dwell captures exactly once.
  localparam logic [3:0] CAP_AT  = 4'(STABLE_CYC - 1);
  localparam logic [7:0] IDLE_TO = 8'(TIMEOUT);

  logic [6:0]      seg_s;
  logic [5:0]      dig_s;
  logic [3:0]      dwell;
  logic [7:0]      idle_cnt;
  logic [5:0][3:0] work_code;
  logic [5:0]      work_blank;
  logic [5:0]      mask;

  // Glyph decode of the sampled segment pattern.
  logic       dec_ok, dec_dark;
  logic [3:0] dec_code;
  always_comb begin
    dec_ok   = 1'b1;
    dec_dark = 1'b0;
    dec_code = 4'h0;
    case (seg_s)
      7'h00: dec_dark = 1'b1;
      7'h3F: dec_code = 4'h0;
      7'h06: dec_code = 4'h1;
      7'h5B: dec_code = 4'h2;
      7'h4F: dec_code = 4'h3;
      7'h66: dec_code = 4'h4;
      7'h6D: dec_code = 4'h5;
      7'h7D: dec_code = 4'h6;
      7'h07: dec_code = 4'h7;
      7'h7F: dec_code = 4'h8;
      7'h6F: dec_code = 4'h9;
`ifdef SEG_SCAN_HEX_EN
      7'h77: dec_code = 4'hA;
      7'h7C: dec_code = 4'hB;
      7'h39: dec_code = 4'hC;
      7'h5E: dec_code = 4'hD;
      7'h79: dec_code = 4'hE;
      7'h71: dec_code = 4'hF;
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  // Select classification: none low = idle, one low = legal, more = multi.
  logic [5:0] sel;
  logic       sel_any, sel_one;
  logic [2:0] sel_idx;
  assign sel     = ~dig_s;
  assign sel_any = |sel;
  assign sel_one = sel_any && ((sel & (sel - 6'd1)) == 6'd0);

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (sel[i]) sel_idx = 3'(i);
  end

  // Idle selects never reach the capture stage, so they cannot raise err.
  logic capture, cap_ok, cap_bad;
  assign capture = (dwell == CAP_AT) && sel_any;
  assign cap_ok  = capture && sel_one && dec_ok;
  assign cap_bad = capture && !(sel_one && dec_ok);

  logic [5:0]      mask_nxt;
  logic            frame_full;
  logic [5:0][3:0] frame_code;
  logic [5:0]      frame_blank;
  assign mask_nxt   = mask | (6'd1 << sel_idx);
  assign frame_full = cap_ok && (mask_nxt == 6'h3F);

  // Working set including the digit being captured this cycle, so a frame
  // completed on this edge publishes the new value too.
  always_comb begin
    frame_code           = work_code;
    frame_blank          = work_blank;
    frame_code[sel_idx]  = dec_code;
    frame_blank[sel_idx] = dec_dark;
  end

  logic       same;
  logic [7:0] idle_nxt;
  logic       lost_nxt;
  assign same     = ({seg, dig} == {seg_s, dig_s});
  assign idle_nxt = sel_one ? 8'd0 : ((idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1);
  assign lost_nxt = !sel_one && (idle_nxt >= IDLE_TO);

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      seg_s      <= 7'h00;
      dig_s      <= 6'h3F;
      dwell      <= 4'd0;
      idle_cnt   <= 8'd0;
      work_code  <= '0;
      work_blank <= 6'h00;
      mask       <= 6'h00;
      digits     <= 24'h0;
      blank      <= 6'h00;
      frame_done <= 1'b0;
      err        <= 1'b0;
      scan_lost  <= 1'b0;
    end else begin
      seg_s      <= seg;
      dig_s      <= dig;
      dwell      <= same ? ((dwell == 4'hF) ? dwell : dwell + 4'd1) : 4'd0;
      idle_cnt   <= idle_nxt;
      scan_lost  <= lost_nxt;
      err        <= cap_bad;
      frame_done <= 1'b0;
      if (cap_ok) begin
        work_code  <= frame_code;
        work_blank <= frame_blank;
        if (frame_full) begin
          digits     <= frame_code;
          blank      <= frame_blank;
          frame_done <= 1'b1;
          mask       <= 6'h00;
        end else begin
          mask <= mask_nxt;
        end
      end
      // Losing the scan abandons any partial frame. A legal capture cannot
      // coincide with this edge, because the select is not legal here.
      if (lost_nxt && !scan_lost) mask <= 6'h00;
    end
  end

endmodule
